// File: rtl/cce_ctrl_pkg.sv
// cce_ctrl_pkg: shared state encoding and error codes for the CCE run sequencer
//   state_e   : sequencer FSM states
//   ERR_*     : err_code values reported to the register bank
package cce_ctrl_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_RECOVER, ST_FINISH} state_e;
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_WDOG  = 2'd1;
   localparam logic [1:0] ERR_ABORT = 2'd2;
endpackage

// File: rtl/cce_wdog_counter.sv
// cce_wdog_counter: saturating run-length counter with clear and limit-hit flag
//   clk_i  : clock
//   rst_ni : synchronous reset, active-low
//   inc_i  : condition present this cycle (run continues)
//   clr_i  : force the run length back to zero
//   hit_o  : this cycle is the LIMIT-th consecutive cycle with inc_i set
module cce_wdog_counter #(
   parameter int W     = 16,
   parameter int LIMIT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic hit_o
);
   logic [W-1:0] cnt_q, cnt_d;
   // a gap in the condition restarts the run, so !inc_i clears like clr_i
   assign cnt_d = (clr_i || !inc_i) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign hit_o = inc_i && !clr_i && (cnt_q >= W'(LIMIT - 1));
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/cce_run_sequencer.sv
// cce_run_sequencer: runs the CCE_1_32 core N times with deadlock recovery
//   ap_clk/ap_rst_n          : clock, synchronous active-low reset
//   cfg_start/cfg_iterations : start request (IDLE only) and invocation count
//   cfg_abort                : abort an active run
//   core_ap_start/ready/done : ap_ctrl handshake with the core
//   deadlock_block           : core deadlock-monitor flag
//   core_soft_rst_n          : soft reset to the core, low during recovery
//   busy/done_pulse          : run status, end-of-run strobe
//   iter_count/err_code      : completed invocations, sticky error
module cce_run_sequencer
   import cce_ctrl_pkg::*;
#(
   parameter int ITER_W     = 32,
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = 1024,
   parameter int RST_CYCLES = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              cfg_start,
   input  logic [ITER_W-1:0] cfg_iterations,
   input  logic              cfg_abort,
   output logic              core_ap_start,
   input  logic              core_ap_ready,
   input  logic              core_ap_done,
   input  logic              deadlock_block,
   output logic              core_soft_rst_n,
   output logic              busy,
   output logic              done_pulse,
   output logic [ITER_W-1:0] iter_count,
   output logic [1:0]        err_code
);
   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   state_e            state_q, state_d;
   logic [ITER_W-1:0] n_q, n_d, iter_q, iter_d, iter_inc;
   logic [1:0]        err_q, err_d;
   logic [RC_W-1:0]   rc_q, rc_d;
   logic              active, done_hit, wd_hit;
   assign active   = (state_q == ST_START) || (state_q == ST_WAIT);
   // a done arriving with ready in START completes the invocation immediately
   assign done_hit = core_ap_done && ((state_q == ST_WAIT) || (state_q == ST_START && core_ap_ready));
   assign iter_inc = iter_q + 1'b1;
   cce_wdog_counter #(.W(WDOG_W), .LIMIT(WDOG_LIMIT)) u_wdog (
      .clk_i  (ap_clk),
      .rst_ni (ap_rst_n),
      .inc_i  (deadlock_block),
      .clr_i  (!active || core_ap_done),
      .hit_o  (wd_hit)
   );
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      iter_d  = iter_q;
      err_d   = err_q;
      rc_d    = '0;
      case (state_q)
         ST_IDLE: if (cfg_start) begin
            n_d     = cfg_iterations;
            iter_d  = '0;
            err_d   = ERR_NONE;
            state_d = (cfg_iterations == '0) ? ST_FINISH : ST_START;
         end
         ST_START, ST_WAIT: begin
            // completion outranks abort, abort outranks the watchdog
            if (done_hit) begin
               iter_d  = iter_inc;
               state_d = (iter_inc == n_q) ? ST_FINISH : ST_START;
            end else if (cfg_abort) begin
               err_d   = ERR_ABORT;
               state_d = ST_RECOVER;
            end else if (wd_hit) begin
               err_d   = ERR_WDOG;
               state_d = ST_RECOVER;
            end else if (state_q == ST_START && core_ap_ready) state_d = ST_WAIT;
         end
         ST_RECOVER: begin
            rc_d    = rc_q + 1'b1;
            state_d = (rc_q == RC_W'(RST_CYCLES - 1)) ? ST_FINISH : ST_RECOVER;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         iter_q  <= '0;
         err_q   <= ERR_NONE;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         iter_q  <= iter_d;
         err_q   <= err_d;
         rc_q    <= rc_d;
      end
   end
   assign core_ap_start   = (state_q == ST_START);
   assign core_soft_rst_n = (state_q != ST_RECOVER);
   assign busy            = (state_q != ST_IDLE);
   assign done_pulse      = (state_q == ST_FINISH);
   assign iter_count      = iter_q;
   assign err_code        = err_q;
endmodule
